bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_pkg.sv | 16 +
 rtl/rr_pick2.sv | 15 +
 rtl/bus_arbiter.sv | 103 ++++++++++
 tb/tb_bus_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared widths, command encodings and FSM state type for bus_arbiter
package bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin pick; on a tie the master other than i_last wins
module rr_pick2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_valid,
  output logic o_gnt
);

  always_comb begin
    o_valid = i_req0 | i_req1;
    o_gnt   = (i_req0 & i_req1) ? ~i_last : i_req1;
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master to one-slave arbiter with round-robin grant and
// combinational pass-through of the owning master's request and the slave's response
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_cmd,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_cmd,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_req,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_cmd,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_ack,
  input  logic [DATA_W-1:0] s_rdata
);

  state_e r_state;
  state_e w_next_state;
  logic   r_last_gnt;
  logic   w_cur;
  logic   w_done;
  logic   w_pick_last;
  logic   w_pick_valid;
  logic   w_pick_gnt;

  // After a completion the finishing master acts as "last", so the same picker
  // yields the other master if it waits, else the current one if it still requests.
  assign w_cur       = (r_state == ST_GNT1);
  assign w_done      = s_req & s_ack;
  assign w_pick_last = (r_state == ST_IDLE) ? r_last_gnt : w_cur;

  rr_pick2 u_pick (
    .i_req0  (m0_req),
    .i_req1  (m1_req),
    .i_last  (w_pick_last),
    .o_valid (w_pick_valid),
    .o_gnt   (w_pick_gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (w_done) r_last_gnt <= w_cur;
    end
  end

  always_comb begin
    w_next_state = r_state;
    s_req        = 1'b0;
    s_addr       = '0;
    s_cmd        = 1'b0;
    s_wdata      = '0;
    m0_ack       = 1'b0;
    m0_rdata     = '0;
    m1_ack       = 1'b0;
    m1_rdata     = '0;

    case (r_state)
      ST_GNT0: begin
        s_req    = m0_req;
        s_addr   = m0_addr;
        s_cmd    = m0_cmd;
        s_wdata  = m0_wdata;
        m0_ack   = s_ack;
        m0_rdata = s_rdata;
      end
      ST_GNT1: begin
        s_req    = m1_req;
        s_addr   = m1_addr;
        s_cmd    = m1_cmd;
        s_wdata  = m1_wdata;
        m1_ack   = s_ack;
        m1_rdata = s_rdata;
      end
      default: ;
    endcase

    if ((r_state == ST_IDLE) || w_done) begin
      if (w_pick_valid) w_next_state = w_pick_gnt ? ST_GNT1 : ST_GNT0;
      else              w_next_state = ST_IDLE;
    end else if (!s_req) begin
      w_next_state = ST_IDLE;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam logic [31:0] A0 = 32'h0000_0010;
  localparam logic [31:0] A1 = 32'h0000_0020;
  localparam logic [31:0] D0 = 32'hA5A5_A5A5;
  localparam logic [31:0] D1 = 32'h5A5A_5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_cmd, m0_ack;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_cmd, m1_ack;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        s_req, s_cmd, s_ack;
  logic [31:0] s_addr, s_wdata, s_rdata;

  int n_vec = 0;
  int n_err = 0;
  int acks0, acks1;

  bus_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_cmd(m0_cmd), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_cmd(m1_cmd), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_cmd(s_cmd), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_addr = A0; m0_cmd = CMD_WRITE; m0_wdata = D0;
    m1_req = 0; m1_addr = A1; m1_cmd = CMD_READ;  m1_wdata = D1;
    s_ack = 0; s_rdata = '0;

    repeat (4) step();
    chk("rst_s_req", s_req, 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_m0_ack", m0_ack, 0);
    rst = 1'b0;

    // single m0 write
    m0_req = 1;
    #1 chk("idle_s_req", s_req, 0);
    step();
    chk("g0_s_req", s_req, 1);
    chk("g0_s_addr", s_addr, A0);
    chk("g0_s_cmd", s_cmd, CMD_WRITE);
    chk("g0_s_wdata", s_wdata, D0);
    s_ack = 1;
    #1 chk("g0_m0_ack", m0_ack, 1);
    chk("g0_m1_ack", m1_ack, 0);

    // both requesting, slave always acks: strict alternation
    m1_req = 1;
    acks0 = 0; acks1 = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("alt_addr_%0d", i), s_addr, (i % 2 == 0) ? A1 : A0);
      acks0 += int'(m0_ack);
      acks1 += int'(m1_ack);
    end
    chk("alt_acks0", acks0, 2);
    chk("alt_acks1", acks1, 2);

    // m1 read with all-ones data
    s_rdata = 32'hFFFF_FFFF;
    step();
    chk("rd_s_addr", s_addr, A1);
    chk("rd_s_cmd", s_cmd, CMD_READ);
    #1 chk("rd_m1_rdata", m1_rdata, 32'hFFFF_FFFF);
    chk("rd_m0_rdata", m0_rdata, 0);
    chk("rd_m1_ack", m1_ack, 1);

    // m0 held for 5 cycles without ack while m1 waits
    step();
    s_ack = 0;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("hold_addr_%0d", i), s_addr, A0);
      chk($sformatf("hold_m1_ack_%0d", i), m1_ack, 0);
      step();
    end
    chk("hold_addr_end", s_addr, A0);
    s_ack = 1;
    #1 chk("hold_m0_ack", m0_ack, 1);
    step();
    chk("hold_then_g1", s_addr, A1);

    // async reset mid-transaction in GNT1
    s_ack = 0;
    #1 rst = 1;
    #1 chk("arst_s_req", s_req, 0);
    chk("arst_s_addr", s_addr, 0);
    chk("arst_m1_ack", m1_ack, 0);
    repeat (2) step();
    rst = 0;
    step();
    chk("post_rst_first_gnt", s_addr, A0);

    // m0 drops request before ack
    m0_req = 0; m1_req = 0;
    #1 chk("drop_s_req_comb", s_req, 0);
    step();
    chk("drop_idle_s_req", s_req, 0);
    chk("drop_idle_s_wdata", s_wdata, 0);
    s_ack = 1;
    #1 chk("idle_ack_m0", m0_ack, 0);
    chk("idle_ack_m1", m1_ack, 0);
    chk("idle_ack_m0_rdata", m0_rdata, 0);
    step();
    chk("idle_stays", s_req, 0);

    // last_gnt untouched by the aborted grant: tie still goes to m0
    s_ack = 0;
    m0_req = 1; m1_req = 1;
    step();
    chk("tie_after_drop", s_addr, A0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
